triangle_assembler: RTL and testbench



---
 rtl/mesh_pkg.sv | 31 +++
 rtl/triangle_assembler_if.sv | 37 +++
 rtl/vertex_buffer.sv | 27 ++
 rtl/triangle_assembler.sv | 185 ++++++++++++++++++
 tb/tb_triangle_assembler.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the triangle assembly path.
// Provides the assembler state encoding, the default widths used by the
// interface and the top level, the face word layout, and a small constant
// helper for sizing comparators.
package mesh_pkg;

    localparam int DEF_IDX_WIDTH    = 12;
    localparam int DEF_COORD_WIDTH  = 24;
    localparam int DEF_MAX_VERTICES = 256;

    typedef enum logic [2:0] {
        IDLE,
        V_CAP,
        V_WAIT,
        F_CAP,
        F_RD,
        EMIT
    } asm_state_t;

    // One face word: i0 sits in the most significant bits.
    typedef struct packed {
        logic [DEF_IDX_WIDTH-1:0] i0;
        logic [DEF_IDX_WIDTH-1:0] i1;
        logic [DEF_IDX_WIDTH-1:0] i2;
    } face_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/triangle_assembler_if.sv
// Bundle of the assembler's stream signals: the model_reader side
// (data_valid, vertex/face words, done flags, next_* advance pulses) and the
// triangle output handshake (tri_valid/tri_ready plus three vertex words).
// master: the assembler. slave: the reader plus the downstream consumer.
interface triangle_assembler_if
    import mesh_pkg::*;
#(
    parameter int VERTEX_DATA_WIDTH = 3 * DEF_COORD_WIDTH,
    parameter int FACE_DATA_WIDTH   = 3 * DEF_IDX_WIDTH
);

    logic                         data_valid;
    logic [VERTEX_DATA_WIDTH-1:0] vertex_data;
    logic                         vertex_buffer_done;
    logic [FACE_DATA_WIDTH-1:0]   face_data;
    logic                         face_buffer_done;
    logic                         next_vertex;
    logic                         next_face;
    logic                         tri_valid;
    logic                         tri_ready;
    logic [VERTEX_DATA_WIDTH-1:0] tri_v0;
    logic [VERTEX_DATA_WIDTH-1:0] tri_v1;
    logic [VERTEX_DATA_WIDTH-1:0] tri_v2;

    modport master (
        input  data_valid, vertex_data, vertex_buffer_done,
        input  face_data, face_buffer_done, tri_ready,
        output next_vertex, next_face, tri_valid, tri_v0, tri_v1, tri_v2
    );

    modport slave (
        output data_valid, vertex_data, vertex_buffer_done,
        output face_data, face_buffer_done, tri_ready,
        input  next_vertex, next_face, tri_valid, tri_v0, tri_v1, tri_v2
    );

endinterface

// File: rtl/vertex_buffer.sv
// Local vertex store for one model.
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. Contents are not reset.
// Ports: clk; wr_en/wr_addr/wr_data write side; rd_addr in, rd_data out.
module vertex_buffer #(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/triangle_assembler.sv
// Drains one model's vertex stream from model_reader into a local buffer,
// then walks the face stream and emits one triangle (three vertex words)
// per face on a valid/ready output. One start pulse handles one model.
// Ports: clk, rstn (sync, active low), start; bus (reader + triangle
// streams, master side); busy, done, vertex_count, err_overflow, err_index.
module triangle_assembler
    import mesh_pkg::*;
#(
    parameter int IDX_WIDTH         = DEF_IDX_WIDTH,
    parameter int COORD_WIDTH       = DEF_COORD_WIDTH,
    parameter int VERTEX_DATA_WIDTH = 3 * COORD_WIDTH,
    parameter int FACE_DATA_WIDTH   = 3 * IDX_WIDTH,
    parameter int MAX_VERTICES      = DEF_MAX_VERTICES,
    parameter int VCNT_WIDTH        = $clog2(MAX_VERTICES + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    triangle_assembler_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic [VCNT_WIDTH-1:0] vertex_count,
    output logic                  err_overflow,
    output logic                  err_index
);

    localparam int ADDR_WIDTH = (MAX_VERTICES > 1) ? $clog2(MAX_VERTICES) : 1;
    // Indices are zero-extended to a common width so no index can wrap
    // into range when compared against vertex_count.
    localparam int CMP_WIDTH  = max_int(IDX_WIDTH, VCNT_WIDTH);
    localparam logic [VCNT_WIDTH-1:0] MAX_COUNT = VCNT_WIDTH'(MAX_VERTICES);

    asm_state_t                   state;
    logic                         armed;
    logic                         wait_cnt;
    logic [1:0]                   rd_cnt;
    logic [IDX_WIDTH-1:0]         idx0, idx1, idx2;
    logic [IDX_WIDTH-1:0]         rd_idx;
    logic                         last_face;
    logic                         face_bad;
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [VERTEX_DATA_WIDTH-1:0] rd_data;
    logic [CMP_WIDTH-1:0]         count_ext;

    assign wr_en   = (state == V_CAP) && (vertex_count < MAX_COUNT);
    assign wr_addr = ADDR_WIDTH'(vertex_count);

    // F_RD issues reads for i0, i1, i2 on its first three cycles.
    always_comb begin
        rd_idx = idx2;
        case (rd_cnt)
            2'd0:    rd_idx = idx0;
            2'd1:    rd_idx = idx1;
            default: rd_idx = idx2;
        endcase
    end

    assign rd_addr = ADDR_WIDTH'(rd_idx);

    vertex_buffer #(
        .DATA_WIDTH (VERTEX_DATA_WIDTH),
        .DEPTH      (MAX_VERTICES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.vertex_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign count_ext = CMP_WIDTH'(vertex_count);
    assign face_bad  = (CMP_WIDTH'(idx0) >= count_ext) ||
                       (CMP_WIDTH'(idx1) >= count_ext) ||
                       (CMP_WIDTH'(idx2) >= count_ext);

    assign busy = (state != IDLE);

    // done marks the cycle the last face retires (transfer or drop), so the
    // model is finished in the same cycle rather than one cycle later.
    assign done = last_face &&
                  (((state == EMIT) && bus.tri_ready) ||
                   ((state == F_RD) && (rd_cnt == 2'd3) && face_bad));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            armed           <= 1'b0;
            wait_cnt        <= 1'b0;
            rd_cnt          <= 2'd0;
            idx0            <= '0;
            idx1            <= '0;
            idx2            <= '0;
            last_face       <= 1'b0;
            vertex_count    <= '0;
            err_overflow    <= 1'b0;
            err_index       <= 1'b0;
            bus.next_vertex <= 1'b0;
            bus.next_face   <= 1'b0;
            bus.tri_valid   <= 1'b0;
            bus.tri_v0      <= '0;
            bus.tri_v1      <= '0;
            bus.tri_v2      <= '0;
        end else begin
            bus.next_vertex <= 1'b0;
            bus.next_face   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        armed        <= 1'b1;
                        vertex_count <= '0;
                        err_overflow <= 1'b0;
                        err_index    <= 1'b0;
                    end
                    if (armed && bus.data_valid) begin
                        armed <= 1'b0;
                        state <= V_CAP;
                    end
                end
                V_CAP: begin
                    if (vertex_count < MAX_COUNT) begin
                        vertex_count <= vertex_count + 1'b1;
                    end else begin
                        err_overflow <= 1'b1;
                    end
                    if (bus.vertex_buffer_done) begin
                        state <= F_CAP;
                    end else begin
                        bus.next_vertex <= 1'b1;
                        wait_cnt        <= 1'b0;
                        state           <= V_WAIT;
                    end
                end
                V_WAIT: begin
                    // Covers the reader's address register plus ROM register.
                    if (wait_cnt) begin
                        state <= V_CAP;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                F_CAP: begin
                    idx0      <= bus.face_data[3*IDX_WIDTH-1 -: IDX_WIDTH];
                    idx1      <= bus.face_data[2*IDX_WIDTH-1 -: IDX_WIDTH];
                    idx2      <= bus.face_data[IDX_WIDTH-1:0];
                    last_face <= bus.face_buffer_done;
                    if (!bus.face_buffer_done) begin
                        bus.next_face <= 1'b1;
                    end
                    rd_cnt <= 2'd0;
                    state  <= F_RD;
                end
                F_RD: begin
                    rd_cnt <= rd_cnt + 2'd1;
                    case (rd_cnt)
                        2'd1:    bus.tri_v0 <= rd_data;
                        2'd2:    bus.tri_v1 <= rd_data;
                        2'd3:    bus.tri_v2 <= rd_data;
                        default: ;
                    endcase
                    if (rd_cnt == 2'd3) begin
                        if (face_bad) begin
                            err_index <= 1'b1;
                            state     <= last_face ? IDLE : F_CAP;
                        end else begin
                            bus.tri_valid <= 1'b1;
                            state         <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.tri_ready) begin
                        bus.tri_valid <= 1'b0;
                        state         <= last_face ? IDLE : F_CAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_assembler.sv
// Self-checking bench for triangle_assembler (MAX_VERTICES = 4).
// A small model_reader model feeds vertex/face words; expected triangles are
// queued when a model is loaded and popped by a monitor on each transfer.
module tb_triangle_assembler;
    import mesh_pkg::*;

    localparam int VDW  = 3 * DEF_COORD_WIDTH;
    localparam int FDW  = 3 * DEF_IDX_WIDTH;
    localparam int MAXV = 4;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       reader_rst;
    logic       busy;
    logic       done;
    logic [2:0] vertex_count;
    logic       err_overflow;
    logic       err_index;

    triangle_assembler_if #(.VERTEX_DATA_WIDTH(VDW), .FACE_DATA_WIDTH(FDW)) bus ();

    triangle_assembler #(.MAX_VERTICES(MAXV)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .vertex_count (vertex_count),
        .err_overflow (err_overflow),
        .err_index    (err_index)
    );

    int checks = 0;
    int errors = 0;

    logic [VDW-1:0] vrom [8];
    face_t          from [8];
    int             num_v = 0;
    int             num_f = 0;
    int             v_addr = 0;
    int             f_addr = 0;
    logic [VDW-1:0] vdata_r;
    logic [FDW-1:0] fdata_r;

    logic [3*VDW-1:0] exp_q [$];
    int nv_cnt, nf_cnt, done_cnt, tri_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reader model: address registers advance on next_*, ROM output registered.
    always @(posedge clk) begin
        if (reader_rst) begin
            v_addr <= 0;
            f_addr <= 0;
        end else begin
            if (bus.next_vertex) v_addr <= v_addr + 1;
            if (bus.next_face)   f_addr <= f_addr + 1;
        end
        vdata_r <= vrom[v_addr % 8];
        fdata_r <= from[f_addr % 8];
    end

    assign bus.vertex_data        = vdata_r;
    assign bus.face_data          = fdata_r;
    assign bus.vertex_buffer_done = (v_addr == num_v - 1);
    assign bus.face_buffer_done   = (f_addr == num_f - 1);

    // Monitor: scoreboard pops, stall stability, pulse spacing and counts.
    initial begin
        logic [3*VDW-1:0] cur;
        logic [3*VDW-1:0] held;
        logic [3*VDW-1:0] exp_t;
        bit stalled, prev_nv, prev_nf;
        stalled = 0; prev_nv = 0; prev_nf = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stalled = 0; prev_nv = 0; prev_nf = 0;
            end else begin
                cur = {bus.tri_v0, bus.tri_v1, bus.tri_v2};
                if (bus.next_vertex) begin
                    nv_cnt++; checks++;
                    if (prev_nv !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL next_vertex_spacing got previous=%0b expected 0", prev_nv);
                    end
                end
                if (bus.next_face) begin
                    nf_cnt++; checks++;
                    if (prev_nf !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL next_face_spacing got previous=%0b expected 0", prev_nf);
                    end
                end
                prev_nv = bus.next_vertex;
                prev_nf = bus.next_face;
                if (done) done_cnt++;
                if (bus.tri_valid) begin
                    if (stalled) begin
                        checks++;
                        if (cur !== held) begin
                            errors++;
                            $display("[TB] FAIL stall_hold got %h expected %h", cur, held);
                        end
                    end
                    if (bus.tri_ready) begin
                        tri_cnt++; checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL unexpected_triangle got %h expected none", cur);
                        end else begin
                            exp_t = exp_q.pop_front();
                            if (cur !== exp_t) begin
                                errors++;
                                $display("[TB] FAIL triangle got %h expected %h", cur, exp_t);
                            end
                        end
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        held    = cur;
                    end
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    task automatic set_vertices(input int nv);
        logic [95:0] r;
        for (int i = 0; i < 8; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            vrom[i] = r[VDW-1:0];
        end
        num_v = nv;
    endtask

    task automatic set_face(input int n, input int a, input int b, input int c);
        from[n].i0 = DEF_IDX_WIDTH'(a);
        from[n].i1 = DEF_IDX_WIDTH'(b);
        from[n].i2 = DEF_IDX_WIDTH'(c);
    endtask

    // Queue the triangles a correct assembler must emit for this model.
    task automatic load_model(input int nf);
        int lim;
        num_f = nf;
        lim = (num_v < MAXV) ? num_v : MAXV;
        nv_cnt = 0; nf_cnt = 0; done_cnt = 0; tri_cnt = 0;
        for (int f = 0; f < nf; f++) begin
            if (int'(from[f].i0) < lim && int'(from[f].i1) < lim && int'(from[f].i2) < lim)
                exp_q.push_back({vrom[from[f].i0], vrom[from[f].i1], vrom[from[f].i2]});
        end
    endtask

    task automatic kick();
        @(posedge clk); #1;
        start = 1; reader_rst = 1;
        @(posedge clk); #1;
        start = 0; reader_rst = 0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!bus.tri_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!bus.tri_valid) begin
            checks++; errors++;
            $display("[TB] FAIL wait_valid_timeout got tri_valid=0 expected 1 within 200 cycles");
        end
    endtask

    // Returns one cycle after done, where busy must already be low.
    task automatic wait_done();
        int cycles = 0;
        while (!done && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL wait_done_timeout got done=0 expected 1 within 400 cycles");
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_after_done got %0b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        checks += 8;
        if (bus.tri_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_tri_valid got %0b expected 0", bus.tri_valid); end
        if (bus.next_vertex !== 1'b0) begin errors++; $display("[TB] FAIL reset_next_vertex got %0b expected 0", bus.next_vertex); end
        if (bus.next_face !== 1'b0)   begin errors++; $display("[TB] FAIL reset_next_face got %0b expected 0", bus.next_face); end
        if (busy !== 1'b0)            begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
        if (done !== 1'b0)            begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", done); end
        if (vertex_count !== 3'd0)    begin errors++; $display("[TB] FAIL reset_vertex_count got %0d expected 0", vertex_count); end
        if (err_overflow !== 1'b0 || err_index !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_errors got %0b%0b expected 00", err_overflow, err_index); end
        if (bus.tri_v0 !== '0)        begin errors++; $display("[TB] FAIL reset_tri_v0 got %h expected 0", bus.tri_v0); end
        rstn = 1;
    endtask

    task automatic test_basic();
        int lat;
        set_vertices(3);
        set_face(0, 0, 1, 2);
        load_model(1);
        bus.tri_ready = 1;
        kick();
        wait_valid(lat);
        checks++;
        if (lat !== 14) begin errors++; $display("[TB] FAIL basic_first_tri_latency got %0d expected 14", lat); end
        wait_done();
        checks += 6;
        if (nv_cnt !== 2)          begin errors++; $display("[TB] FAIL basic_next_vertex got %0d expected 2", nv_cnt); end
        if (nf_cnt !== 0)          begin errors++; $display("[TB] FAIL basic_next_face got %0d expected 0", nf_cnt); end
        if (done_cnt !== 1)        begin errors++; $display("[TB] FAIL basic_done_pulses got %0d expected 1", done_cnt); end
        if (tri_cnt !== 1)         begin errors++; $display("[TB] FAIL basic_tri_count got %0d expected 1", tri_cnt); end
        if (vertex_count !== 3'd3) begin errors++; $display("[TB] FAIL basic_vertex_count got %0d expected 3", vertex_count); end
        if (err_overflow !== 1'b0 || err_index !== 1'b0)
            begin errors++; $display("[TB] FAIL basic_errors got %0b%0b expected 00", err_overflow, err_index); end
    endtask

    task automatic test_backpressure();
        int lat;
        set_vertices(3);
        set_face(0, 2, 1, 0);
        set_face(1, 0, 0, 1);
        load_model(2);
        bus.tri_ready = 0;
        kick();
        wait_valid(lat);
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (bus.tri_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid got %0b expected 1", bus.tri_valid); end
        bus.tri_ready = 1;
        wait_done();
        checks += 3;
        if (tri_cnt !== 2)   begin errors++; $display("[TB] FAIL stall_tri_count got %0d expected 2", tri_cnt); end
        if (nf_cnt !== 1)    begin errors++; $display("[TB] FAIL stall_next_face got %0d expected 1", nf_cnt); end
        if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL stall_queue_left got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_bad_index();
        set_vertices(3);
        set_face(0, 1, 2, 0);
        set_face(1, 0, 1, 3);
        load_model(2);
        bus.tri_ready = 1;
        kick();
        wait_done();
        checks += 4;
        if (err_index !== 1'b1)    begin errors++; $display("[TB] FAIL badidx_err_index got %0b expected 1", err_index); end
        if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL badidx_err_overflow got %0b expected 0", err_overflow); end
        if (tri_cnt !== 1)         begin errors++; $display("[TB] FAIL badidx_tri_count got %0d expected 1", tri_cnt); end
        if (done_cnt !== 1)        begin errors++; $display("[TB] FAIL badidx_done_pulses got %0d expected 1", done_cnt); end
    endtask

    task automatic test_overflow();
        set_vertices(6);
        set_face(0, 3, 2, 1);
        set_face(1, 0, 3, 0);
        load_model(2);
        bus.tri_ready = 1;
        kick();
        wait_done();
        checks += 5;
        if (vertex_count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_vertex_count got %0d expected 4", vertex_count); end
        if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err_overflow got %0b expected 1", err_overflow); end
        if (err_index !== 1'b0)    begin errors++; $display("[TB] FAIL ovf_err_index got %0b expected 0", err_index); end
        if (nv_cnt !== 5)          begin errors++; $display("[TB] FAIL ovf_next_vertex got %0d expected 5", nv_cnt); end
        if (tri_cnt !== 2)         begin errors++; $display("[TB] FAIL ovf_tri_count got %0d expected 2", tri_cnt); end
    endtask

    task automatic test_single();
        int lat;
        set_vertices(1);
        set_face(0, 0, 0, 0);
        load_model(1);
        bus.tri_ready = 1;
        kick();
        wait_valid(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("[TB] FAIL single_latency got %0d expected 8", lat); end
        wait_done();
        checks += 4;
        if (nv_cnt !== 0)          begin errors++; $display("[TB] FAIL single_next_vertex got %0d expected 0", nv_cnt); end
        if (nf_cnt !== 0)          begin errors++; $display("[TB] FAIL single_next_face got %0d expected 0", nf_cnt); end
        if (tri_cnt !== 1)         begin errors++; $display("[TB] FAIL single_tri_count got %0d expected 1", tri_cnt); end
        if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL single_err_overflow got %0b expected 0", err_overflow); end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_vertices(3);
        set_face(0, 0, 1, 2);
        set_face(1, 2, 0, 1);
        load_model(2);
        bus.tri_ready = 0;
        kick();
        wait_valid(lat);
        rstn = 0;
        @(posedge clk); #1;
        checks += 2;
        if (bus.tri_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tri_valid got %0b expected 0", bus.tri_valid); end
        if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL midrst_busy got %0b expected 0", busy); end
        exp_q.delete();
        rstn = 1;
        load_model(2);
        bus.tri_ready = 1;
        kick();
        wait_done();
        checks += 3;
        if (tri_cnt !== 2)         begin errors++; $display("[TB] FAIL midrst_tri_count got %0d expected 2", tri_cnt); end
        if (vertex_count !== 3'd3) begin errors++; $display("[TB] FAIL midrst_vertex_count got %0d expected 3", vertex_count); end
        if (done_cnt !== 1)        begin errors++; $display("[TB] FAIL midrst_done_pulses got %0d expected 1", done_cnt); end
    endtask

    initial begin
        rstn           = 0;
        start          = 0;
        reader_rst     = 1;
        bus.data_valid = 1;
        bus.tri_ready  = 1;
        for (int i = 0; i < 8; i++) begin
            vrom[i] = '0;
            from[i] = '0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_index();
        test_overflow();
        test_single();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
